// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - pushbutton synchronizer, debouncer and press/release pulse generator
//
// Conditions a raw, bouncy, asynchronous pushbutton pin for use in the clk
// domain. The pin passes through a SYNC_STAGES flip-flop chain and is
// normalized so that 1 means pressed. A stability counter then accepts a
// level change only after it has held for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous, active-high reset
//   btn_raw       in   raw button pin, asynchronous to clk and bouncy
//   btn_state     out  debounced level, 1 = pressed (polarity normalized)
//   press         out  one-cycle pulse when btn_state goes 0->1
//   release_pulse out  one-cycle pulse when btn_state goes 1->0

module button_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_state,
  output logic press,
  output logic release_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM     = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  // Inactive pin level: an active-low button idles high.
  localparam logic          INACTIVE = ACTIVE_LOW;

  typedef enum logic [1:0] {
    UP,
    DOWN_PEND,
    DOWN,
    UP_PEND
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state;
  logic [CW-1:0]          cnt;

  // Synchronizer: only sync_q[0] samples the asynchronous pin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{INACTIVE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Normalized, synchronized button: 1 = pressed regardless of pin polarity.
  assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // Debounce FSM. Entering a pending state counts the first stable cycle, so
  // reaching TERM means DEBOUNCE_CYCLES consecutive stable samples. Any
  // disagreeing sample while pending drops back and restarts qualification.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= UP;
      cnt           <= '0;
      btn_state     <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        UP: begin
          if (s) begin
            state <= DOWN_PEND;
            cnt   <= CNT_ONE;
          end
        end
        DOWN_PEND: begin
          if (!s) begin
            state <= UP;
            cnt   <= '0;
          end else if (cnt == TERM) begin
            state     <= DOWN;
            cnt       <= '0;
            btn_state <= 1'b1;
            press     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DOWN: begin
          if (!s) begin
            state <= UP_PEND;
            cnt   <= CNT_ONE;
          end
        end
        UP_PEND: begin
          if (s) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == TERM) begin
            state         <= UP;
            cnt           <= '0;
            btn_state     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= UP;
          cnt       <= '0;
          btn_state <= 1'b0;
        end
      endcase
    end
  end

endmodule
